// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared states, opcodes, ALU encodings and fault codes for the CPU sequencer
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_FAULT
   } state_e;

   typedef enum logic [2:0] {
      CLS_J,
      CLS_BEQ,
      CLS_RTYPE,
      CLS_ADDI,
      CLS_LW,
      CLS_SW,
      CLS_ILLEGAL
   } iclass_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] FC_NONE    = 2'b00;
   localparam logic [1:0] FC_ILLEGAL = 2'b01;
   localparam logic [1:0] FC_IMEM_TO = 2'b10;
   localparam logic [1:0] FC_DMEM_TO = 2'b11;

endpackage

// File: rtl/instr_decoder.sv
// rtl/instr_decoder.sv - combinational opcode/funct classifier and ALU operation lookup
module instr_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_e    iclass,
   output logic [2:0] alucontrol
);

   always_comb begin
      iclass     = CLS_ILLEGAL;
      alucontrol = ALU_ADD;
      case (opcode)
         OP_J:    iclass = CLS_J;
         OP_BEQ: begin
            iclass     = CLS_BEQ;
            alucontrol = ALU_SUB;
         end
         OP_ADDI: iclass = CLS_ADDI;
         OP_LW:   iclass = CLS_LW;
         OP_SW:   iclass = CLS_SW;
         OP_RTYPE: begin
            iclass = CLS_RTYPE;
            case (funct)
               FN_ADD:  alucontrol = ALU_ADD;
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: iclass = CLS_ILLEGAL;
            endcase
         end
         default: iclass = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multicycle fetch/decode/exec/mem control FSM with retire counter and fault trap
module cpu_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             run,
   output logic             imem_req,
   input  logic             imem_ack,
   input  logic [31:0]      imem_rdata,
   output logic             dmem_req,
   output logic             dmem_we,
   input  logic             dmem_ack,
   input  logic             zero,
   output logic [31:0]      instr,
   output logic             pc_enable,
   output logic             regwrite,
   output logic             memtoreg,
   output logic             alusrc,
   output logic             regdst,
   output logic             pcsrc,
   output logic             jump,
   output logic [2:0]       alucontrol,
   output logic [CNT_W-1:0] instret,
   output logic             busy,
   output logic             fault,
   output logic [1:0]       fault_code
);

   // The wait counter only has to hold 0..TIMEOUT-1; the last no-ack cycle traps.
   localparam int                WAIT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [31:0]       instr_q, instr_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic [1:0]        fault_code_q, fault_code_d;
   logic              retire;

   iclass_e    iclass;
   logic [2:0] dec_alu;

   instr_decoder u_decoder (
      .opcode     (instr_q[31:26]),
      .funct      (instr_q[5:0]),
      .iclass     (iclass),
      .alucontrol (dec_alu)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         instr_q      <= '0;
         wait_q       <= '0;
         instret_q    <= '0;
         fault_code_q <= FC_NONE;
      end else begin
         state_q      <= state_d;
         instr_q      <= instr_d;
         wait_q       <= wait_d;
         instret_q    <= instret_d;
         fault_code_q <= fault_code_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      instr_d      = instr_q;
      wait_d       = '0;
      instret_d    = instret_q;
      fault_code_d = fault_code_q;
      retire       = 1'b0;
      imem_req     = 1'b0;
      dmem_req     = 1'b0;
      dmem_we      = 1'b0;
      pc_enable    = 1'b0;
      regwrite     = 1'b0;
      memtoreg     = 1'b0;
      alusrc       = 1'b0;
      regdst       = 1'b0;
      pcsrc        = 1'b0;
      jump         = 1'b0;
      alucontrol   = 3'b000;

      case (state_q)
         ST_IDLE: begin
            if (run) state_d = ST_FETCH;
         end
         ST_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               instr_d = imem_rdata;
               state_d = ST_DECODE;
            end else if (wait_q == WAIT_LAST) begin
               state_d      = ST_FAULT;
               fault_code_d = FC_IMEM_TO;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_DECODE: begin
            case (iclass)
               CLS_J: begin
                  jump      = 1'b1;
                  pc_enable = 1'b1;
                  retire    = 1'b1;
               end
               CLS_BEQ: begin
                  alucontrol = dec_alu;
                  pcsrc      = zero;
                  pc_enable  = 1'b1;
                  retire     = 1'b1;
               end
               CLS_RTYPE, CLS_ADDI: state_d = ST_EXEC;
               CLS_LW, CLS_SW:      state_d = ST_MEM;
               default: begin
                  state_d      = ST_FAULT;
                  fault_code_d = FC_ILLEGAL;
               end
            endcase
         end
         ST_EXEC: begin
            regwrite   = 1'b1;
            pc_enable  = 1'b1;
            alucontrol = dec_alu;
            regdst     = (iclass == CLS_RTYPE);
            alusrc     = (iclass == CLS_ADDI);
            retire     = 1'b1;
         end
         ST_MEM: begin
            dmem_req   = 1'b1;
            dmem_we    = (iclass == CLS_SW);
            alusrc     = 1'b1;
            alucontrol = ALU_ADD;
            if (dmem_ack) begin
               pc_enable = 1'b1;
               regwrite  = (iclass == CLS_LW);
               memtoreg  = (iclass == CLS_LW);
               retire    = 1'b1;
            end else if (wait_q == WAIT_LAST) begin
               state_d      = ST_FAULT;
               fault_code_d = FC_DMEM_TO;
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_FAULT: state_d = ST_FAULT;
         default:  state_d = ST_IDLE;
      endcase

      if (retire) begin
         instret_d = instret_q + CNT_W'(1);
         state_d   = run ? ST_FETCH : ST_IDLE;
      end
   end

   assign instr      = instr_q;
   assign instret    = instret_q;
   assign busy       = (state_q != ST_IDLE);
   assign fault      = (state_q == ST_FAULT);
   assign fault_code = fault_code_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard bench for cpu_sequencer with handshake memories
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        run;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack;
   logic        zero;
   logic [31:0] instr;
   logic        pc_enable, regwrite, memtoreg, alusrc, regdst, pcsrc, jump;
   logic [2:0]  alucontrol;
   logic [2:0]  instret;
   logic        busy;
   logic        fault;
   logic [1:0]  fault_code;

   typedef struct {
      logic [10:0] ctl;
      int          cyc;
      int          dreq;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   exp_ret  = 0;
   int   icyc     = 0;
   int   dcnt     = 0;

   cpu_sequencer #(.TIMEOUT(4), .CNT_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
      .imem_req   (imem_req),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_ack   (dmem_ack),
      .zero       (zero),
      .instr      (instr),
      .pc_enable  (pc_enable),
      .regwrite   (regwrite),
      .memtoreg   (memtoreg),
      .alusrc     (alusrc),
      .regdst     (regdst),
      .pcsrc      (pcsrc),
      .jump       (jump),
      .alucontrol (alucontrol),
      .instret    (instret),
      .busy       (busy),
      .fault      (fault),
      .fault_code (fault_code)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic logic [12:0] all_outs();
      return {imem_req, dmem_req, dmem_we, pc_enable, regwrite, memtoreg,
              alusrc, regdst, pcsrc, jump, alucontrol};
   endfunction

   function automatic logic [2:0] alu_of(input logic [5:0] fn);
      case (fn)
         6'h20:   return 3'b010;
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         default: return 3'b111;
      endcase
   endfunction

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            exp_ret = 0;
            icyc    = 0;
            dcnt    = 0;
         end else begin
            if (busy) icyc++;
            if (dmem_req) dcnt++;
            if (regwrite) check("regwrite_only_at_retire", 32'(pc_enable), 32'd1);
            if (pc_enable) begin
               if (sb.size() == 0) begin
                  check("unexpected_retire", 32'(pc_enable), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("retire_ctl", 32'({regwrite, memtoreg, alusrc, regdst, pcsrc, jump,
                                           alucontrol, dmem_req, dmem_we}), 32'(e.ctl));
                  check("retire_cycles", 32'(icyc), 32'(e.cyc));
                  check("dmem_req_cycles", 32'(dcnt), 32'(e.dreq));
                  check("instret_before_retire", 32'(instret), 32'(exp_ret));
               end
               exp_ret = (exp_ret + 1) % 8;
               icyc    = 0;
               dcnt    = 0;
            end
         end
      end
   endtask

   task automatic fetch_word(input logic [31:0] word, input int iw);
      for (int i = 0; i < 20; i++) begin
         if (imem_req) break;
         @(posedge clk); #1;
      end
      if (!imem_req) check("imem_req_seen", 32'(imem_req), 32'd1);
      repeat (iw) begin @(posedge clk); #1; end
      imem_ack   = 1'b1;
      imem_rdata = word;
      @(posedge clk); #1;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
   endtask

   task automatic do_instr(input logic [31:0] word, input int iw, input int dw,
                           input logic z, input bit drop_run);
      exp_t       e;
      logic [5:0] op;
      op     = word[31:26];
      e.dreq = 0;
      case (op)
         6'h02:   begin e.ctl = {6'b000001, 3'b000, 2'b00};       e.cyc = 2 + iw; end
         6'h04:   begin e.ctl = {4'b0000, z, 1'b0, 3'b110, 2'b00}; e.cyc = 2 + iw; end
         6'h00:   begin e.ctl = {6'b100100, alu_of(word[5:0]), 2'b00}; e.cyc = 3 + iw; end
         6'h08:   begin e.ctl = {6'b101000, 3'b010, 2'b00};       e.cyc = 3 + iw; end
         6'h23:   begin e.ctl = {6'b111000, 3'b010, 2'b10};       e.cyc = 3 + iw + dw; e.dreq = dw + 1; end
         default: begin e.ctl = {6'b001000, 3'b010, 2'b11};       e.cyc = 3 + iw + dw; e.dreq = dw + 1; end
      endcase
      sb.push_back(e);
      zero = z;
      fetch_word(word, iw);
      if (op == 6'h23 || op == 6'h2B) begin
         @(posedge clk); #1;
         repeat (dw) begin @(posedge clk); #1; end
         dmem_ack = 1'b1;
         @(posedge clk); #1;
         dmem_ack = 1'b0;
      end else if (op == 6'h00 || op == 6'h08) begin
         @(posedge clk); #1;
         if (drop_run) run = 1'b0;
         @(posedge clk); #1;
      end else begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_reset();
      reset    = 1'b0;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      reset = 1'b1;
   endtask

   initial begin
      int n;
      reset      = 1'b1;
      run        = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = '0;
      dmem_ack   = 1'b0;
      zero       = 1'b0;
      fork
         monitor();
      join_none
      #2 reset = 1'b0;
      #1;
      check("reset_outs", 32'(all_outs()), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_instr", instr, 32'd0);
      check("reset_instret", 32'(instret), 32'd0);
      check("reset_fault", 32'({fault, fault_code}), 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      imem_ack   = 1'b1;
      imem_rdata = 32'hFC00_0000;
      @(posedge clk); #1;
      imem_ack = 1'b0;
      check("ack_without_req_instr", instr, 32'd0);
      check("ack_without_req_busy", 32'(busy), 32'd0);

      run = 1'b1;
      @(posedge clk); #1;
      check("run_enters_fetch", 32'(imem_req), 32'd1);

      do_instr(32'h012A_4020, 0, 0, 1'b0, 1'b0);
      do_instr(32'h8D28_0004, 0, 3, 1'b0, 1'b0);
      do_instr(32'h1109_FFFF, 0, 0, 1'b1, 1'b0);
      do_instr(32'h1109_FFFF, 0, 0, 1'b0, 1'b0);
      do_instr(32'h012A_4022, 1, 0, 1'b1, 1'b0);
      do_instr(32'h012A_4024, 0, 0, 1'b0, 1'b0);
      do_instr(32'h012A_4025, 2, 0, 1'b0, 1'b0);
      do_instr(32'h012A_402A, 0, 0, 1'b0, 1'b0);
      do_instr(32'h2128_0005, 0, 0, 1'b0, 1'b0);
      do_instr(32'hAD28_0004, 2, 0, 1'b0, 1'b0);
      do_instr(32'h0800_0010, 1, 0, 1'b0, 1'b0);
      do_instr(32'h2128_0005, 3, 2, 1'b0, 1'b0);
      do_instr(32'h012A_4020, 0, 0, 1'b0, 1'b1);
      check("idle_after_run_drop", 32'(busy), 32'd0);
      repeat (2) begin @(posedge clk); #1; end
      check("parked_in_idle", 32'({busy, imem_req}), 32'd0);
      check("instret_wrapped", 32'(instret), 32'd5);
      check("no_fault_after_boundary_ack", 32'(fault), 32'd0);

      run = 1'b1;
      fetch_word(32'h8D28_0004, 0);
      @(posedge clk); #1;
      check("mem_req_before_reset", 32'(dmem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      check("async_reset_dmem_req", 32'(dmem_req), 32'd0);
      check("async_reset_busy", 32'(busy), 32'd0);
      check("async_reset_instr", instr, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;

      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (imem_req) n++;
         if (fault) break;
      end
      check("imem_timeout_cycles", 32'(n), 32'd4);
      check("imem_timeout_code", 32'({fault, fault_code}), 32'b110);
      check("imem_timeout_outs", 32'(all_outs()), 32'd0);

      do_reset();
      fetch_word(32'h8D28_0004, 0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (dmem_req) n++;
         if (fault) break;
      end
      check("dmem_timeout_cycles", 32'(n), 32'd4);
      check("dmem_timeout_code", 32'({fault, fault_code}), 32'b111);

      do_reset();
      zero = 1'b1;
      fetch_word(32'hFC00_0000, 0);
      @(posedge clk); #1;
      check("illegal_op_code", 32'({fault, fault_code}), 32'b101);
      check("illegal_op_outs", 32'(all_outs()), 32'd0);
      repeat (5) begin @(posedge clk); #1; end
      check("fault_sticky_with_run", 32'({busy, fault, fault_code}), 32'b1101);
      check("fault_sticky_outs", 32'(all_outs()), 32'd0);

      do_reset();
      check("reset_clears_fault", 32'({fault, fault_code}), 32'd0);
      fetch_word(32'h012A_4021, 0);
      @(posedge clk); #1;
      check("illegal_funct_code", 32'({fault, fault_code}), 32'b101);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);

      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer for the 32-bit MIPS-style CPU datapath. It fetches instructions over a req/ack instruction-memory handshake and holds them in an internal instruction register. It decodes each instruction and drives the datapath control strobes (`pc_enable`, `regwrite`, `memtoreg`, `alusrc`, `regdst`, `pcsrc`, `jump`, `alucontrol`) state by state. It also runs a req/ack data-memory handshake for `lw`/`sw`, counts retired instructions, and traps on illegal opcodes or memory timeouts.

## Interface
- `TIMEOUT`, default 255: maximum cycles a memory request may wait for ack before fault; must be ≥ 1.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `run` in 1: level-sensitive enable to start and continue execution.
- `imem_req` out 1: instruction fetch request.
- `imem_ack` in 1: fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 32: fetched instruction word.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a write; valid while `dmem_req` is high.
- `dmem_ack` in 1: data access complete; read data is valid at the datapath in the same cycle.
- `zero` in 1: ALU zero flag from the datapath.
- `instr` out 32: instruction register, driven to the datapath.
- `pc_enable`, `regwrite`, `memtoreg`, `alusrc`, `regdst`, `pcsrc`, `jump` out 1 each: datapath controls.
- `alucontrol` out 3: ALU operation.
- `instret` out CNT_W: count of retired instructions.
- `busy` out 1: high in any state other than IDLE.
- `fault` out 1: sticky fault flag.
- `fault_code` out 2: 00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, FAULT.
- **IDLE:** if `run`=1, go to FETCH; otherwise stay.
- **FETCH:** `imem_req`=1. On `imem_ack`, load `imem_rdata` into `instr` and go to DECODE.
- **DECODE:** one cycle. Classify `instr[31:26]` and `instr[5:0]`.
  - `j` (000010): assert `jump`=1 and `pc_enable`=1, then retire.
  - `beq` (000100): assert `alucontrol`=110 and `pcsrc`=`zero` (combinational from the same cycle) with `pc_enable`=1, then retire.
  - R-type (000000) and `addi` (001000): go to EXEC.
  - `lw` (100011) and `sw` (101011): go to MEM.
  - Any other opcode, or an R-type with an unknown funct: go to FAULT with code 01.
- **EXEC:** one cycle. Assert `regwrite`=1 and `pc_enable`=1, then retire.
  - R-type: `regdst`=1, `alusrc`=0.
  - `addi`: `regdst`=0, `alusrc`=1, `alucontrol`=010.
  - R-type funct to `alucontrol`: add 100000→010, sub 100010→110, and 100100→000, or 100101→001, slt 101010→111.
- **MEM:** `dmem_req`=1, `dmem_we`=(opcode is `sw`), `alusrc`=1, `alucontrol`=010, all held until `dmem_ack`.
  - On ack for `lw`: assert `regwrite`=1, `memtoreg`=1, `regdst`=0, `pc_enable`=1, then retire.
  - On ack for `sw`: assert `pc_enable`=1, then retire.
- **Retire:** `instret` increments by 1 and wraps modulo 2^CNT_W. Next state is FETCH if `run`=1, otherwise IDLE.
- **Timeout:** a wait counter clears on entry to FETCH or MEM and increments every cycle without ack. When it reaches TIMEOUT with still no ack, go to FAULT with code 10 (FETCH) or 11 (MEM).
- **FAULT:** `fault`=1 and all strobes and requests are 0. The block stays in FAULT until reset; `run` is ignored.
- **Strobe defaults:** every control strobe is 0 outside the cycles listed above. `pc_enable` and `regwrite` are never high for more than one cycle per instruction.

## Timing
- **Reset (async, `reset`=0):** state=IDLE; `instr`=0; `instret`=0; `fault`=0; `fault_code`=00; every strobe and request output is 0. Outputs take these values immediately, mid-handshake included; a pending request is abandoned.
- **Ack sampling:**
  - An ack is sampled on the rising edge only while the matching req is high.
  - An ack in the first req cycle is legal, giving a minimum FETCH of 1 cycle.
  - An ack while req is low is ignored.
- **Minimum latency with zero-wait memory:**
  - `j`/`beq`: 2 cycles (FETCH, DECODE).
  - R-type/`addi`: 3 cycles.
  - `lw`/`sw`: 3 cycles.
- **Timeout boundary:** ack arriving in the same cycle the counter reaches TIMEOUT counts as success; ack wins.
- **`run` changes:** dropping `run` mid-instruction completes that instruction, then parks in IDLE. Raising `run` in IDLE enters FETCH on the next edge.

## Structure
- Package `cpu_ctrl_pkg` holds:
  - the state enum;
  - the opcode and funct constants;
  - the `alucontrol` encodings (ADD=010, SUB=110, AND=000, OR=001, SLT=111);
  - the fault codes.
- Sub-module `instr_decoder`: combinational. Takes opcode and funct; outputs instruction class (J, BEQ, RTYPE, ADDI, LW, SW, ILLEGAL) and `alucontrol`.
- The sequencer holds the FSM, the instruction register, the wait counter and `instret`.

## Test plan
- **Reset then `add`:** reset, `run`=1, zero-wait imem returns 0x012A4020 (add $8,$9,$10) → `regwrite`=1, `regdst`=1, `alucontrol`=010 in cycle 3, `pc_enable` high exactly once, `instret`=1.
- **`lw` with wait states:** imem returns 0x8D280004, dmem acks after 3 wait cycles → `dmem_req` high for 4 cycles with `dmem_we`=0, then `memtoreg`=1 and `regwrite`=1 in the ack cycle.
- **`beq`:** instruction 0x1109FFFF with `zero`=1 → `pcsrc`=1 and `pc_enable`=1 in DECODE. Repeat with `zero`=0 → `pcsrc`=0.
- **Illegal opcode:** imem returns 0xFC000000 → FAULT, `fault_code`=01, all strobes 0, stays there with `run` held at 1.
- **Timeout:** with TIMEOUT=4, imem never acks → `fault_code`=10 after 4 cycles in FETCH. Separately, ack exactly at the boundary cycle → no fault.
- **Mid-operation reset and `run` drop:** assert `reset`=0 during MEM → `dmem_req` drops asynchronously and state=IDLE. Drop `run` during EXEC → the instruction retires, then `busy`=0.
